// File: rtl/usb_packet_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : usb_packet_transmitter
// Description : Device-side USB full-speed packet transmitter (clock48 domain).
//               Sends SYNC, PID, optional payload and CRC16, and EOP onto D+/D-
//               with NRZI encoding and bit stuffing.
//               Optional feature macro: USB_TX_CRC16_EN. When defined, CRC16 is
//               generated over the payload and appended. When undefined, data
//               packets end right after the payload.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_packet_transmitter #(
  parameter int CLOCKS_PER_BIT = 4,
  parameter int LENGTH_WIDTH   = 10
) (
  input  logic                    clock48,
  input  logic                    reset_n,
  input  logic                    tx_start,
  input  logic [3:0]              tx_pid,
  input  logic [LENGTH_WIDTH-1:0] tx_length,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    tx_busy,
  output logic                    tx_done,
  output logic                    tx_error,
  output logic                    usb_dp,
  output logic                    usb_dn,
  output logic                    usb_oe
);

  localparam int DIV_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLOCKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_PID     = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_CRC     = 3'd4;
  localparam logic [2:0] S_EOP_SE0 = 3'd5;
  localparam logic [2:0] S_EOP_J   = 3'd6;

  logic [2:0]              r_state;
  logic [2:0]              w_state_next;
  logic [DIV_W-1:0]        r_div;
  logic [2:0]              r_bit;      // index of the last field bit put on the line
  logic [2:0]              r_ones;     // consecutive ones sent, saturating at 6
  logic [7:0]              r_shift;    // field byte being serialised
  logic [3:0]              r_pid;
  logic [LENGTH_WIDTH-1:0] r_bytes;    // payload bytes still to be fetched
  logic                    r_line;     // NRZI line level, 1 = J
  logic                    r_se0;
  logic                    r_done;
  logic                    r_error;
`ifdef USB_TX_CRC16_EN
  logic [15:0]             r_crc;
  logic                    r_crc_byte; // 0 = sending crc[15:8], 1 = crc[7:0]
  logic                    w_crc_fb;
`endif

  logic       w_busy;
  logic       w_tick;
  logic       w_serial;
  logic       w_stuff;
  logic       w_adv;
  logic       w_last;
  logic       w_field_end;
  logic       w_more;
  logic       w_need_byte;
  logic       w_underrun;
  logic       w_accept;
  logic       w_reject;
  logic       w_next_serial;
  logic       w_emit;
  logic       w_bit;
  logic [2:0] w_after_data;

  // Bit-time strobes, field boundaries and start qualification.
  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_tick      = w_busy && (r_div == C_DIV_LAST);
    w_serial    = (r_state == S_SYNC) || (r_state == S_PID) ||
                  (r_state == S_DATA) || (r_state == S_CRC);
    w_stuff     = w_tick && w_serial && (r_ones == 3'd6);
    w_adv       = w_tick && w_serial && !w_stuff;
`ifdef USB_TX_CRC16_EN
    w_last      = (r_bit == 3'd7) && ((r_state != S_CRC) || r_crc_byte);
    w_after_data = S_CRC;
`else
    w_last      = (r_bit == 3'd7);
    w_after_data = S_EOP_SE0;
`endif
    w_field_end = w_adv && w_last;
    w_more      = (r_bytes != '0);
    // A payload byte is fetched at the end of the PID of a data packet or
    // at the end of every payload byte while bytes remain.
    w_need_byte = w_field_end && w_more &&
                  (((r_state == S_PID) && r_pid[0]) || (r_state == S_DATA));
    w_underrun  = w_need_byte && !tx_valid;
    w_accept    = !w_busy && tx_start && tx_pid[1];
    w_reject    = !w_busy && tx_start && !tx_pid[1];
  end

  // FSM state register.
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_SYNC;
      S_SYNC:    if (w_field_end) w_state_next = S_PID;
      S_PID: begin
        if (w_field_end) begin
          if (!r_pid[0])   w_state_next = S_EOP_SE0;
          else if (w_more) w_state_next = tx_valid ? S_DATA : S_EOP_SE0;
          else             w_state_next = w_after_data;
        end
      end
      S_DATA: begin
        if (w_field_end) begin
          if (w_more) w_state_next = tx_valid ? S_DATA : S_EOP_SE0;
          else        w_state_next = w_after_data;
        end
      end
      S_CRC:     if (w_field_end) w_state_next = S_EOP_SE0;
      S_EOP_SE0: if (w_tick && r_bit[0]) w_state_next = S_EOP_J;
      S_EOP_J:   if (w_tick) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Select the next data bit to be NRZI-encoded onto the line.
  always_comb begin
    w_next_serial = (w_state_next == S_SYNC) || (w_state_next == S_PID) ||
                    (w_state_next == S_DATA) || (w_state_next == S_CRC);
    w_emit = w_accept || (w_adv && w_next_serial);
    w_bit  = r_shift[r_bit + 3'd1];
    if (w_accept) w_bit = 1'b0;
    else if ((r_state == S_SYNC) && w_last) w_bit = r_pid[0];
    else if (w_need_byte) w_bit = tx_data[0];
`ifdef USB_TX_CRC16_EN
    else if (w_state_next == S_CRC) w_bit = ~r_crc[15];
    w_crc_fb = r_crc[15] ^ w_bit;
`endif
  end

  // Datapath: bit clock, serialiser, stuffing, CRC and line level.
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      r_div      <= '0;
      r_bit      <= 3'd0;
      r_ones     <= 3'd0;
      r_shift    <= 8'h00;
      r_pid      <= 4'h0;
      r_bytes    <= '0;
      r_line     <= 1'b1;
      r_se0      <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef USB_TX_CRC16_EN
      r_crc      <= 16'hFFFF;
      r_crc_byte <= 1'b0;
`endif
    end else begin
      r_done  <= w_tick && (r_state == S_EOP_J);
      r_error <= w_reject || w_underrun;

      if (w_accept)    r_div <= '0;
      else if (w_busy) r_div <= (r_div == C_DIV_LAST) ? '0 : r_div + DIV_W'(1);

      if (w_accept) begin
        r_pid   <= tx_pid;
        r_bytes <= tx_length;
        r_shift <= 8'h80;           // SYNC pattern, LSB first
`ifdef USB_TX_CRC16_EN
        r_crc      <= 16'hFFFF;
        r_crc_byte <= 1'b0;
`endif
      end

      if ((r_state == S_SYNC) && w_field_end) r_shift <= {~r_pid, r_pid};

      if (w_need_byte && tx_valid) begin
        r_shift <= tx_data;
        r_bytes <= r_bytes - LENGTH_WIDTH'(1);
      end

      // Data 0 toggles the line, data 1 holds it.
      if (w_emit) begin
        r_line <= r_line ^ ~w_bit;
        r_ones <= w_bit ? ((r_ones == 3'd6) ? 3'd6 : r_ones + 3'd1) : 3'd0;
        r_bit  <= w_accept ? 3'd0 : r_bit + 3'd1;
      end

      if (w_stuff) begin
        r_line <= ~r_line;
        r_ones <= 3'd0;
      end

`ifdef USB_TX_CRC16_EN
      if (w_emit && (w_state_next == S_DATA))
        r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h8005 : 16'h0000);
      if (w_emit && (w_state_next == S_CRC)) begin
        r_crc <= {r_crc[14:0], 1'b0};
        if ((r_state == S_CRC) && (r_bit == 3'd7)) r_crc_byte <= 1'b1;
      end
`endif

      if ((w_state_next == S_EOP_SE0) && (r_state != S_EOP_SE0)) begin
        r_se0 <= 1'b1;
        r_bit <= 3'd0;
      end else if ((r_state == S_EOP_SE0) && w_tick) begin
        r_bit <= r_bit + 3'd1;
      end

      if ((r_state == S_EOP_SE0) && (w_state_next == S_EOP_J)) begin
        r_se0  <= 1'b0;
        r_line <= 1'b1;
      end
    end
  end

  // Outputs; pins released to J whenever idle.
  always_comb begin
    tx_busy  = w_busy;
    usb_oe   = w_busy;
    tx_ready = w_need_byte;
    tx_done  = r_done;
    tx_error = r_error;
    usb_dp   = !w_busy ? 1'b1 : (r_se0 ? 1'b0 : r_line);
    usb_dn   = !w_busy ? 1'b0 : (r_se0 ? 1'b0 : ~r_line);
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_packet_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_packet_transmitter
// Description : Self-checking bench for usb_packet_transmitter. A packet-level
//               model builds the expected line symbols per bit time; the DUT
//               line is also decoded back into bytes like a host would.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_packet_transmitter;

`ifdef USB_TX_CRC16_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clock48  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid   = 4'h0;
  logic [9:0] tx_length = 10'd0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error, usb_dp, usb_dn, usb_oe;

  usb_packet_transmitter #(.CLOCKS_PER_BIT(4), .LENGTH_WIDTH(10)) dut (
    .clock48(clock48), .reset_n(reset_n), .tx_start(tx_start), .tx_pid(tx_pid),
    .tx_length(tx_length), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .usb_dp(usb_dp), .usb_dn(usb_dn), .usb_oe(usb_oe)
  );

  always #5 clock48 = ~clock48;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: stuffed bit stream, line symbols (0=K 1=J 2=SE0), events.
  bit         s_bits[$];
  int         stuff_pos[$];
  int         exp_ready[$];
  int         sym[$];
  int         dsym[$];
  int         exp_err;
  int         exp_T;
  int         ones_m;
  bit         trunc_m;
  logic [7:0] pl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input bit b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h8005 : 16'h0000);
  endfunction

  function automatic void push_bit(input bit b);
    s_bits.push_back(b);
    if (b) ones_m++; else ones_m = 0;
    if (ones_m == 6) begin
      stuff_pos.push_back(s_bits.size());
      s_bits.push_back(1'b0);
      ones_m = 0;
    end
  endfunction

  task automatic build(input logic [3:0] pid, input int len, input int ur);
    logic [7:0]  sb;
    logic [15:0] crc;
    int          line;
    s_bits.delete(); stuff_pos.delete(); exp_ready.delete(); sym.delete();
    ones_m = 0; exp_err = -1; trunc_m = 1'b0; crc = 16'hFFFF;
    sb = 8'h80;
    for (int i = 0; i < 8; i++) push_bit(sb[i]);
    sb = {~pid, pid};
    for (int i = 0; i < 8; i++) push_bit(sb[i]);
    if (pid[1:0] == 2'b11) begin
      for (int k = 0; k < len; k++) begin
        exp_ready.push_back(4 * s_bits.size());
        if (k == ur) begin
          exp_err = 4 * s_bits.size() + 1;
          trunc_m = 1'b1;
          break;
        end
        sb = pl[k];
        for (int i = 0; i < 8; i++) begin
          push_bit(sb[i]);
          crc = crc_bit(crc, sb[i]);
        end
      end
      if (!trunc_m && CRC_ON)
        for (int i = 15; i >= 0; i--) push_bit(~crc[i]);
    end
    line = 1;
    foreach (s_bits[i]) begin
      if (!s_bits[i]) line = 1 - line;
      sym.push_back(line);
    end
    sym.push_back(2); sym.push_back(2); sym.push_back(1);
    exp_T = sym.size();
  endtask

  // Host-side decode of the captured DUT line.
  task automatic decode(input logic [3:0] pid, input int len, input int ur);
    bit          db[$];
    int          prev, ones, nb, ncrc;
    bit          skip;
    logic [7:0]  by;
    logic [15:0] res;
    prev = 1; ones = 0; skip = 1'b0;
    foreach (dsym[i]) begin
      bit b;
      if (dsym[i] == 2) break;
      b = (dsym[i] == prev);
      prev = dsym[i];
      if (skip) begin skip = 1'b0; continue; end
      db.push_back(b);
      if (b) ones++; else ones = 0;
      if (ones == 6) begin skip = 1'b1; ones = 0; end
    end
    nb   = (pid[1:0] != 2'b11) ? 0 : (trunc_m ? ur : len);
    ncrc = (pid[1:0] == 2'b11 && !trunc_m && CRC_ON) ? 2 : 0;
    check("dec_bits", db.size(), 16 + 8 * (nb + ncrc));
    if (db.size() == 16 + 8 * (nb + ncrc)) begin
      for (int i = 0; i < 8; i++) by[i] = db[8 + i];
      check("dec_pid", by, {~pid, pid});
      for (int k = 0; k < nb; k++) begin
        for (int i = 0; i < 8; i++) by[i] = db[16 + 8 * k + i];
        check("dec_payload", by, pl[k]);
      end
      if (ncrc != 0) begin
        res = 16'hFFFF;
        for (int i = 16; i < db.size(); i++) res = crc_bit(res, db[i]);
        check("dec_residual", res, 16'h800D);
      end
    end
  endtask

  task automatic run_packet(input logic [3:0] pid, input int len, input int ur,
                            input int poke, input bit chain);
    int k;
    build(pid, len, ur);
    k = 0;
    dsym.delete();
    if (!chain) @(negedge clock48);
    for (int c = 0; c <= 4 * exp_T + 1; c++) begin
      bit busy_e, dp_e, dn_e, rdy_e;
      busy_e = (c >= 1) && (c <= 4 * exp_T);
      dp_e = 1'b1; dn_e = 1'b0;
      if (busy_e) begin
        dp_e = (sym[(c - 1) / 4] == 1);
        dn_e = (sym[(c - 1) / 4] == 0);
      end
      rdy_e = 1'b0;
      foreach (exp_ready[i]) if (exp_ready[i] == c) rdy_e = 1'b1;
      check("oe", usb_oe, busy_e);
      check("busy", tx_busy, busy_e);
      check("dp", usb_dp, dp_e);
      check("dn", usb_dn, dn_e);
      check("ready", tx_ready, rdy_e);
      check("done", tx_done, (c == 4 * exp_T + 1) || (chain && c == 0));
      check("error", tx_error, c == exp_err);
      if (busy_e && (c % 4 == 2))
        dsym.push_back((!usb_dp && !usb_dn) ? 2 : int'(usb_dp));
      tx_start  = (c == 0) || (c == poke);
      tx_pid    = (c == poke) ? 4'b0011 : pid;
      tx_length = (c == poke) ? 10'd7 : 10'(len);
      tx_data   = pl[k % 16];
      tx_valid  = (k != ur);
      if (tx_ready === 1'b1) k++;
      if (c < 4 * exp_T + 1) @(negedge clock48);
    end
    tx_start = 1'b0;
    decode(pid, len, ur);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clock48);
    check("rst_oe", usb_oe, 1'b0);
    check("rst_dp", usb_dp, 1'b1);
    check("rst_dn", usb_dn, 1'b0);
    check("rst_ready", tx_ready, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_error", tx_error, 1'b0);
    reset_n = 1'b1;

    // ACK, with an ignored start request while busy.
    run_packet(4'b0010, 0, -1, 10, 1'b0);
    check("pin_ack_T", exp_T, 19);
    check("pin_ack_noready", exp_ready.size(), 0);

    // DATA0, empty payload.
    run_packet(4'b0011, 0, -1, -1, 1'b0);
    check("pin_data0_T", exp_T, CRC_ON ? 35 : 19);

    // DATA1, single byte 0x01.
    pl[0] = 8'h01;
    run_packet(4'b1011, 1, -1, -1, 1'b0);
    check("pin_data1_ready", exp_ready[0], 64);

    // DATA1, 0xFF 0xFF: stuffing inside the payload.
    pl[0] = 8'hFF; pl[1] = 8'hFF;
    run_packet(4'b1011, 2, -1, -1, 1'b0);
    check("pin_stuff0", stuff_pos[0], 22);
    check("pin_stuff1", stuff_pos[1], 29);

    // Underrun at the second payload byte.
    pl[0] = 8'hA5; pl[1] = 8'h5A; pl[2] = 8'h00; pl[3] = 8'hFF;
    run_packet(4'b0011, 4, 1, -1, 1'b0);
    check("pin_under_err", exp_err, 97);
    check("pin_under_T", exp_T, 27);

    // Back-to-back: new starts issued in the tx_done cycle.
    pl[0] = 8'h7E; pl[1] = 8'h80; pl[2] = 8'h3C;
    run_packet(4'b0011, 3, -1, -1, 1'b0);
    run_packet(4'b1010, 0, -1, -1, 1'b1);
    run_packet(4'b1110, 0, -1, -1, 1'b1);

    // Rejected token PID.
    @(negedge clock48);
    for (int c = 0; c < 6; c++) begin
      check("rej_oe", usb_oe, 1'b0);
      check("rej_busy", tx_busy, 1'b0);
      check("rej_error", tx_error, c == 1);
      tx_start = (c == 0);
      tx_pid   = 4'b1001;
      @(negedge clock48);
    end
    tx_start = 1'b0;

    // Asynchronous reset in the middle of the payload.
    tx_start = 1'b1; tx_pid = 4'b1011; tx_length = 10'd4;
    tx_data = 8'h55; tx_valid = 1'b1;
    @(negedge clock48);
    tx_start = 1'b0;
    repeat (80) @(negedge clock48);
    check("pre_rst_busy", tx_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_oe", usb_oe, 1'b0);
    check("arst_busy", tx_busy, 1'b0);
    check("arst_dp", usb_dp, 1'b1);
    check("arst_dn", usb_dn, 1'b0);
    check("arst_ready", tx_ready, 1'b0);
    @(negedge clock48);
    reset_n = 1'b1;

    // Transmitter recovers to IDLE after reset.
    run_packet(4'b0010, 0, -1, -1, 1'b0);

    @(negedge clock48);
    check("end_done", tx_done, 1'b0);
    check("end_oe", usb_oe, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
